ysyx_22040632_icache_ctrl: RTL and testbench

Sequencing controller for the 2-way, 32-set instruction cache tag array. The cache uses a 21-bit tag, a 5-bit index and 64-byte lines. The block accepts fetch requests, drives the tag array lookup, and picks a victim from the per-way age bits. On a miss it runs an 8-beat refill burst into the data array, then commits the tag. It also sequences fence.i invalidation. Sits between the IFU and the memory arbiter.

---
 rtl/ysyx_22040632_icache_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ysyx_22040632_icache_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040632_icache_ctrl.sv
// Sequencing controller for the 2-way instruction cache: lookup, victim choice,
// burst refill into the data array, tag commit and fence.i invalidation.
module ysyx_22040632_icache_ctrl #(
  parameter int BEATS = 8,
  parameter int TAG_W = 21,
  parameter int IDX_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [31:0]                req_addr,
  output logic                       req_ready,
  output logic                       resp_valid,
  output logic [31:0]                resp_data,
  input  logic                       fence_i,
  output logic                       fence_ack,
  output logic [TAG_W-1:0]           tag_addr_tag,
  output logic [IDX_W-1:0]           tag_addr_index,
  output logic                       tag_wen_n,
  output logic                       tag_w_way,
  output logic                       tag_fence,
  input  logic                       hit_1st,
  input  logic                       hit_2nd,
  input  logic                       age_1st,
  input  logic                       age_2nd,
  output logic                       data_way,
  output logic [IDX_W-1:0]           data_index,
  output logic [$clog2(BEATS)-1:0]   data_beat,
  output logic                       data_wen,
  output logic [63:0]                data_wdata,
  input  logic [63:0]                data_rdata,
  output logic                       mem_arvalid,
  output logic [31:0]                mem_araddr,
  input  logic                       mem_arready,
  input  logic                       mem_rvalid,
  input  logic [63:0]                mem_rdata,
  input  logic                       mem_rlast,
  output logic                       mem_rready
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = 32 - TAG_W - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, REFILL, TAGWR, FENCE} state_t;

  state_t            state;
  logic [31:2]       addr;
  logic              victim;
  logic [BEAT_W-1:0] beat;
  logic              hit;

  // Word-aligned fetches: the byte offset and the second age bit carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{req_addr[1:0], age_2nd};

  assign hit            = hit_1st | hit_2nd;
  assign tag_addr_tag   = addr[31 -: TAG_W];
  assign tag_addr_index = addr[OFF_W +: IDX_W];
  assign data_index     = addr[OFF_W +: IDX_W];
  assign mem_araddr     = {addr[31:OFF_W], {OFF_W{1'b0}}};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch sees the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      victim      <= 1'b0;
      beat        <= '0;
      req_ready   <= 1'b0;
      mem_arvalid <= 1'b0;
      mem_rready  <= 1'b0;
      tag_wen_n   <= 1'b1;
      tag_w_way   <= 1'b0;
      tag_fence   <= 1'b0;
      fence_ack   <= 1'b0;
    end else begin
      tag_wen_n <= 1'b1;
      tag_fence <= 1'b0;
      fence_ack <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_ready && fence_i) begin
            req_ready <= 1'b0;
            tag_fence <= 1'b1;
            fence_ack <= 1'b1;
            state     <= FENCE;
          end else if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            addr      <= req_addr[31:2];
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            // Way 0 unless it is the most recently used one.
            victim      <= age_1st;
            mem_arvalid <= 1'b1;
            state       <= MISS_AR;
          end
        end
        MISS_AR: begin
          if (mem_arready) begin
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b1;
            beat        <= '0;
            state       <= REFILL;
          end
        end
        REFILL: begin
          if (mem_rvalid) begin
            beat <= beat + 1'b1;
            if (mem_rlast) begin
              mem_rready <= 1'b0;
              tag_wen_n  <= 1'b0;
              tag_w_way  <= victim;
              state      <= TAGWR;
            end
          end
        end
        TAGWR: state <= LOOKUP;
        FENCE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    resp_valid = 1'b0;
    resp_data  = '0;
    data_way   = 1'b0;
    data_beat  = '0;
    data_wen   = 1'b0;
    data_wdata = '0;
    case (state)
      LOOKUP: begin
        data_way  = hit_2nd;
        data_beat = addr[3 +: BEAT_W];
        if (hit) begin
          resp_valid = 1'b1;
          resp_data  = addr[2] ? data_rdata[63:32] : data_rdata[31:0];
        end
      end
      REFILL: begin
        data_way   = victim;
        data_beat  = beat;
        data_wen   = mem_rvalid;
        data_wdata = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040632_icache_ctrl.sv
// Bench for the icache controller: tag/data array and memory environment plus
// a set-associative LRU reference model of which lines are resident.
module tb_ysyx_22040632_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, resp_valid, fence_i, fence_ack;
  logic [31:0] req_addr, resp_data;
  logic [20:0] tag_addr_tag;
  logic [4:0]  tag_addr_index, data_index;
  logic        tag_wen_n, tag_w_way, tag_fence;
  logic        hit_1st, hit_2nd, age_1st, age_2nd;
  logic        data_way, data_wen;
  logic [2:0]  data_beat;
  logic [63:0] data_wdata, data_rdata;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rlast, mem_rready;
  logic [31:0] mem_araddr;
  logic [63:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int last_beat = 7;

  always #5 clk = ~clk;

  ysyx_22040632_icache_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .fence_i(fence_i), .fence_ack(fence_ack),
    .tag_addr_tag(tag_addr_tag), .tag_addr_index(tag_addr_index),
    .tag_wen_n(tag_wen_n), .tag_w_way(tag_w_way), .tag_fence(tag_fence),
    .hit_1st(hit_1st), .hit_2nd(hit_2nd), .age_1st(age_1st), .age_2nd(age_2nd),
    .data_way(data_way), .data_index(data_index), .data_beat(data_beat),
    .data_wen(data_wen), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
    .mem_rready(mem_rready)
  );

  // Tag array, data array and memory environment.
  logic        tv [2][32];
  logic [20:0] tt [2][32];
  logic        ag [2][32];
  logic [63:0] dm [2][32][8];
  logic        burst = 1'b0;
  logic [31:0] bline = '0;
  logic [2:0]  bcnt  = '0;

  always_comb begin
    hit_1st    = tv[0][tag_addr_index] && (tt[0][tag_addr_index] == tag_addr_tag);
    hit_2nd    = tv[1][tag_addr_index] && (tt[1][tag_addr_index] == tag_addr_tag);
    age_1st    = ag[0][tag_addr_index];
    age_2nd    = ag[1][tag_addr_index];
    data_rdata = dm[data_way][data_index][data_beat];
  end

  always @(posedge clk) begin
    if (rst) begin
      burst <= 1'b0;
      bcnt  <= '0;
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 32; s++) begin
          tv[w][s] <= 1'b0;
          ag[w][s] <= 1'b0;
        end
    end else begin
      if (resp_valid) begin
        ag[hit_2nd][tag_addr_index]  <= 1'b1;
        ag[!hit_2nd][tag_addr_index] <= 1'b0;
      end
      if (!tag_wen_n) begin
        tv[tag_w_way][tag_addr_index] <= 1'b1;
        tt[tag_w_way][tag_addr_index] <= tag_addr_tag;
      end
      if (tag_fence)
        for (int w = 0; w < 2; w++)
          for (int s = 0; s < 32; s++) begin
            tv[w][s] <= 1'b0;
            ag[w][s] <= 1'b0;
          end
      if (data_wen) dm[data_way][data_index][data_beat] <= data_wdata;
      if (mem_arvalid && mem_arready) begin
        burst <= 1'b1;
        bline <= mem_araddr;
        bcnt  <= '0;
      end
      if (mem_rvalid && mem_rready) begin
        bcnt <= bcnt + 1'b1;
        if (mem_rlast) burst <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] lo;
    lo = bline + {26'd0, bcnt, 3'b000};
    mem_arready <= ($urandom_range(0, 1) == 1);
    mem_rvalid  <= burst && !rst && ($urandom_range(0, 3) != 0);
    mem_rdata   <= {~lo, lo};
    mem_rlast   <= (bcnt == 3'(last_beat));
  end

  // Reference model: which line sits in which way, and the MRU way per set.
  bit          mv  [2][32];
  logic [20:0] mt  [2][32];
  int          mru [32];

  function automatic void model_clear();
    for (int s = 0; s < 32; s++) begin
      mv[0][s] = 1'b0;
      mv[1][s] = 1'b0;
      mru[s]   = -1;
    end
  endfunction

  function automatic void model_access(input logic [31:0] a, output bit hit, output bit way);
    int idx;
    idx = int'(a[10:6]);
    hit = 1'b0;
    way = 1'b0;
    for (int w = 0; w < 2; w++)
      if (mv[w][idx] && mt[w][idx] == a[31:11]) begin
        hit = 1'b1;
        way = w[0];
      end
    if (!hit) begin
      way         = (mru[idx] == 0);
      mv[way][idx] = 1'b1;
      mt[way][idx] = a[31:11];
    end
    mru[idx] = int'(way);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One IFU fetch, optionally with fence.i raised alongside it or mid-refill.
  task automatic fetch(input logic [31:0] a, input bit with_fence, input bit fence_mid,
                       output logic obs_way);
    bit          e_hit, e_way, wa, raised, wr_bad, tf_bad, overlap;
    logic [31:0] e_word, lo, word, ar_addr;
    int          cyc, acc, resp_cyc, ack_cyc, resp_n, ack_n, ar_n, tagw, wr_n;
    logic        tagw_way;
    if (with_fence) model_clear();
    model_access(a, e_hit, e_way);
    e_word = a[2] ? ~{a[31:3], 3'b000} : {a[31:3], 3'b000};
    cyc = 0; acc = -1; resp_cyc = -1; ack_cyc = -1; resp_n = 0; ack_n = 0;
    ar_n = 0; tagw = 0; wr_n = 0; tagw_way = 1'bx; word = 'x; ar_addr = 'x;
    raised = 0; wr_bad = 0; tf_bad = 0; overlap = 0;
    req_valid = 1'b1;
    req_addr  = a;
    fence_i   = with_fence;
    while (cyc < 400 && (resp_cyc < 0 || fence_i)) begin
      wa = req_valid && req_ready && !fence_i;
      @(negedge clk);
      #1;
      cyc++;
      if (wa) begin
        acc = cyc;
        req_valid = 1'b0;
      end
      if (resp_valid) begin
        resp_cyc = cyc;
        resp_n++;
        word = resp_data;
      end
      if (resp_valid && fence_ack) overlap = 1;
      if (tag_fence !== fence_ack) tf_bad = 1;
      if (fence_ack) begin
        ack_cyc = cyc;
        ack_n++;
        fence_i = 1'b0;
      end
      if (mem_arvalid) begin
        ar_n++;
        ar_addr = mem_araddr;
      end
      if (!tag_wen_n) begin
        tagw++;
        tagw_way = tag_w_way;
      end
      if (data_wen) begin
        lo = {a[31:6], 6'b0} + 32'(wr_n * 8);
        if (data_beat !== 3'(wr_n) || data_way !== e_way || data_index !== a[10:6] ||
            data_wdata !== {~lo, lo}) wr_bad = 1;
        wr_n++;
        if (fence_mid && !raised && wr_n == 3) begin
          fence_i = 1'b1;
          raised  = 1;
        end
      end
    end
    req_valid = 1'b0;
    if (raised) model_clear();
    check("resp_seen", 64'(resp_cyc >= 0), 64'(1));
    check("resp_data", 64'(word), 64'(e_word));
    check("resp_once", 64'(resp_n), 64'(1));
    check("resp_ack_overlap", 64'(overlap), 64'(0));
    if (e_hit) begin
      check("hit_latency", 64'(resp_cyc - acc), 64'(0));
      check("hit_no_arvalid", 64'(ar_n), 64'(0));
      check("hit_no_tagwr", 64'(tagw), 64'(0));
    end else begin
      check("miss_araddr", 64'(ar_addr), 64'({a[31:6], 6'b0}));
      check("refill_beats", 64'(wr_n), 64'(last_beat + 1));
      check("refill_writes", 64'(wr_bad), 64'(0));
      check("tagwr_once", 64'(tagw), 64'(1));
      check("victim_way", 64'(tagw_way), 64'(e_way));
    end
    if (with_fence || raised) begin
      check("fence_ack_once", 64'(ack_n), 64'(1));
      check("tag_fence_with_ack", 64'(tf_bad), 64'(0));
    end
    if (with_fence) check("fence_before_lookup", 64'(ack_cyc < acc), 64'(1));
    if (raised)     check("fence_after_resp", 64'(ack_cyc > resp_cyc), 64'(1));
    obs_way = tagw_way;
  endtask

  task automatic fence_only();
    int  cyc;
    bit  seen;
    cyc = 0;
    seen = 0;
    fence_i = 1'b1;
    while (cyc < 50 && !seen) begin
      @(negedge clk);
      #1;
      cyc++;
      if (fence_ack) begin
        seen = 1;
        check("fence_tag_fence", 64'(tag_fence), 64'(1));
        fence_i = 1'b0;
      end
    end
    fence_i = 1'b0;
    check("fence_ack_seen", 64'(seen), 64'(1));
    @(negedge clk);
    #1;
    check("fence_pulse_one_cycle", 64'({fence_ack, tag_fence}), 64'(0));
    model_clear();
  endtask

  logic [20:0] tag_pool [4];

  initial begin
    logic        w;
    logic [31:0] a;
    int          r, n, cyc;
    bit          wa;
    req_valid = 1'b0;
    req_addr  = '0;
    fence_i   = 1'b0;
    tag_pool[0] = 21'h100000; tag_pool[1] = 21'h120000;
    tag_pool[2] = 21'h140000; tag_pool[3] = 21'h160000;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", 64'({req_ready, resp_valid, fence_ack, tag_fence, mem_arvalid,
                             mem_rready, data_wen, data_way, tag_w_way, tag_wen_n}), 64'(1));
    check("reset_addr", 64'({mem_araddr, tag_addr_tag, tag_addr_index, data_beat}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("ready_after_reset", 64'(req_ready), 64'(1));

    fetch(32'h8000_0040, 0, 0, w);
    check("cold_miss_way0", 64'(w), 64'(0));
    fetch(32'h8000_0044, 0, 0, w);
    fetch(32'h9000_0040, 0, 0, w);
    check("second_fill_way1", 64'(w), 64'(1));
    fetch(32'h8000_0048, 0, 0, w);
    fetch(32'hA000_0040, 0, 0, w);
    check("victim_after_hit_a", 64'(w), 64'(1));
    fetch(32'hA000_0050, 0, 0, w);
    fetch(32'hB000_0040, 0, 0, w);
    check("victim_after_hit_way1", 64'(w), 64'(0));
    fetch(32'hC000_0080, 1, 0, w);
    fetch(32'h8000_0100, 0, 1, w);

    for (int i = 0; i < 40; i++) begin
      a = {tag_pool[$urandom_range(0, 3)], 5'($urandom_range(1, 3)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'b00};
      r = $urandom_range(0, 9);
      if (r == 2) fence_only();
      fetch(a, r == 0, r == 1, w);
    end

    fence_only();
    last_beat = 3;
    fetch(32'h8000_0048, 0, 0, w);
    last_beat = 7;

    req_valid = 1'b1;
    req_addr  = 32'hD000_0040;
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 300) begin
      wa = req_valid && req_ready;
      @(negedge clk);
      #1;
      cyc++;
      if (wa) req_valid = 1'b0;
      if (data_wen) n++;
    end
    req_valid = 1'b0;
    check("reset_test_three_beats", 64'(n), 64'(3));
    rst = 1'b1;
    #1;
    check("midburst_reset_ctrl", 64'({req_ready, resp_valid, fence_ack, tag_fence, mem_arvalid,
                                      mem_rready, data_wen, data_way, tag_w_way, tag_wen_n}), 64'(1));
    check("midburst_reset_data", 64'(data_wdata), 64'(0));
    check("midburst_reset_addr", 64'({mem_araddr, tag_addr_tag, tag_addr_index, data_beat}), 64'(0));
    @(negedge clk);
    #1;
    check("reset_hold_tag_wen_n", 64'({tag_wen_n, mem_arvalid, data_wen}), 64'(4));
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    #1;
    check("idle_after_reset", 64'(req_ready), 64'(1));
    fetch(32'h8000_0040, 0, 0, w);
    check("post_reset_miss_way0", 64'(w), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

endmodule
